// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit framer: start bit, WIDTH data bits LSB first, optional parity bit, stop bit.
// Each bit lasts one clk. tx_out and busy are driven directly from registers.
module uart_tx_frame_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_valid,
  input  logic [WIDTH-1:0] p_data,
  input  logic             par_en,
  input  logic             par_bit,
  output logic             tx_out,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             par_en_q;
  logic             par_q;
  logic             tx_q;
  logic             busy_q;
  logic             accept;

  // STOP also accepts, which makes back-to-back frames possible with no idle gap.
  assign accept = data_valid && ((state_q == IDLE) || (state_q == STOP));

  // NOTE: every register here uses <= so all of them update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_en_q  <= 1'b0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, STOP: begin
          if (accept) begin
            state_q  <= START;
            shift_q  <= p_data;
            par_en_q <= par_en;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
          end else begin
            state_q  <= IDLE;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
          end
        end
        START: begin
          // The parity stage output becomes valid one clk after accept, so it is sampled here.
          par_q     <= par_bit;
          state_q   <= DATA;
          bit_cnt_q <= '0;
          tx_q      <= shift_q[0];
          shift_q   <= shift_q >> 1;
        end
        DATA: begin
          if (bit_cnt_q == LAST_BIT) begin
            if (par_en_q) begin
              state_q <= PARITY;
              tx_q    <= par_q;
            end else begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
          end
        end
        PARITY: begin
          state_q <= STOP;
          tx_q    <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Directed bench for uart_tx_frame_ctrl. The expected line and busy sequences are hand-written vectors.
// In each vector the first sample is the leftmost bit.
module tb_uart_tx_frame_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             data_valid;
  logic [WIDTH-1:0] p_data;
  logic             par_en;
  logic             par_bit;
  logic             tx_out;
  logic             busy;

  int errors;
  int checks;

  uart_tx_frame_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_valid (data_valid),
    .p_data     (p_data),
    .par_en     (par_en),
    .par_bit    (par_bit),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at #1 after an edge. Raises data_valid for exactly one edge (the accept edge).
  task automatic send(input logic [WIDTH-1:0] data, input logic pe, input logic pb);
    data_valid = 1'b1;
    p_data     = data;
    par_en     = pe;
    par_bit    = pb;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
  endtask

  // Checks n consecutive samples, one per clk. If inj_at >= 0, a request is driven after sample inj_at.
  task automatic run_seq(input string tag, input logic [31:0] tx_exp, input logic [31:0] busy_exp,
                         input int n, input int inj_at, input logic [WIDTH-1:0] inj_data,
                         input logic inj_pe, input logic inj_pb);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s tx[%0d]", tag, i), {31'd0, tx_out}, {31'd0, tx_exp[n-1-i]});
      check($sformatf("%s busy[%0d]", tag, i), {31'd0, busy}, {31'd0, busy_exp[n-1-i]});
      if (i == inj_at) begin
        data_valid = 1'b1;
        p_data     = inj_data;
        par_en     = inj_pe;
        par_bit    = inj_pb;
      end
      @(posedge clk);
      #1;
      data_valid = 1'b0;
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    rst        = 1'b1;
    data_valid = 1'b0;
    p_data     = '0;
    par_en     = 1'b0;
    par_bit    = 1'b0;

    #3;
    check("reset tx", {31'd0, tx_out}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // A5, even parity 0: start, 1,0,1,0,0,1,0,1, parity, stop, then idle
    send(8'hA5, 1'b1, 1'b0);
    run_seq("a5_par", {20'd0, 1'b0, 8'b10100101, 1'b0, 1'b1, 1'b1},
            {20'd0, 11'h7FF, 1'b0}, 12, -1, '0, 1'b0, 1'b0);

    // 80 without parity: 10 clk frame
    send(8'h80, 1'b0, 1'b0);
    run_seq("80_nopar", {21'd0, 1'b0, 8'b00000001, 1'b1, 1'b1},
            {21'd0, 10'h3FF, 1'b0}, 11, -1, '0, 1'b0, 1'b0);

    // Back-to-back: 81 then 3C requested during the STOP cycle (sample 9)
    send(8'h81, 1'b0, 1'b0);
    run_seq("b2b", {11'd0, 1'b0, 8'b10000001, 1'b1, 1'b0, 8'b00111100, 1'b1, 1'b1},
            {11'd0, 20'hFFFFF, 1'b0}, 21, 9, 8'h3C, 1'b0, 1'b0);

    // FF requested mid-DATA, with par_bit flipped to 0: frame and latched parity 1 unchanged
    send(8'hA5, 1'b1, 1'b1);
    run_seq("ignore_ff", {19'd0, 1'b0, 8'b10100101, 1'b1, 1'b1, 1'b1, 1'b1},
            {19'd0, 11'h7FF, 2'b00}, 13, 3, 8'hFF, 1'b0, 1'b0);

    // Asynchronous reset in the middle of DATA
    send(8'h00, 1'b0, 1'b0);
    run_seq("pre_rst", 32'b0000, 32'b1111, 4, -1, '0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst tx", {31'd0, tx_out}, 32'd1);
    check("async_rst busy", {31'd0, busy}, 32'd0);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(8'h55, 1'b1, 1'b0);
    run_seq("55_after_rst", {20'd0, 1'b0, 8'b10101010, 1'b0, 1'b1, 1'b1},
            {20'd0, 11'h7FF, 1'b0}, 12, -1, '0, 1'b0, 1'b0);

    // Reset again, then 20 idle clocks
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("idle tx[%0d]", i), {31'd0, tx_out}, 32'd1);
      check($sformatf("idle busy[%0d]", i), {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
    end

    // Odd parity: 00 with par_bit=1, so the parity slot is 1
    send(8'h00, 1'b1, 1'b1);
    run_seq("odd_par", {20'd0, 1'b0, 8'b00000000, 1'b1, 1'b1, 1'b1},
            {20'd0, 11'h7FF, 1'b0}, 12, -1, '0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
